// File: rtl/rr_mux8_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux8_arbiter
// Description : Round-robin burst arbiter and select sequencer for an 8-to-1
//               WIDTH-bit datapath mux with a valid/ready downstream consumer.
//               Optional forced grant release enabled by RR_MUX_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux8_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [7:0]         req,
  input  logic [7:0]         last,
  input  logic [8*WIDTH-1:0] data,
  output logic [7:0]         gnt,
  output logic [2:0]         sel,
  output logic [WIDTH-1:0]   y,
  output logic               y_valid,
  output logic               y_last,
  input  logic               y_ready,
  output logic               busy,
  output logic               timeout
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_ptr, w_ptr_nxt;
  logic [2:0] r_sel, w_sel_nxt;
  logic [7:0] r_gnt, w_gnt_nxt;
  logic       r_timeout, w_timeout_nxt;
  logic [2:0] w_pick, w_idx;
  logic       w_found;
  logic       w_rel_last, w_abort, w_force;

  // First requesting lane at or above ptr, wrapping modulo 8.
  always_comb begin
    w_pick  = r_ptr;
    w_idx   = r_ptr;
    w_found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w_idx = r_ptr + 3'(i);
      if (req[w_idx] && !w_found) begin
        w_pick  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign busy       = (r_state == ST_GRANT);
  assign y_valid    = busy & req[r_sel];
  assign y_last     = y_valid & last[r_sel];
  assign y          = data[int'(r_sel)*WIDTH +: WIDTH];
  assign gnt        = r_gnt;
  assign sel        = r_sel;
  assign timeout    = r_timeout;
  assign w_rel_last = y_valid & y_ready & last[r_sel];
  assign w_abort    = busy & ~req[r_sel];

`ifdef RR_MUX_TIMEOUT_EN
  localparam logic [7:0] C_HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] r_hold;

  // Zero throughout IDLE, so it reads 0 in the first GRANT cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               r_hold <= 8'd0;
    else if (r_state == ST_IDLE) r_hold <= 8'd0;
    else                        r_hold <= r_hold + 8'd1;
  end

  assign w_force = busy & req[r_sel] & (r_hold == C_HOLD_LAST) & ~w_rel_last;
`else
  assign w_force = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_sel_nxt     = r_sel;
    w_gnt_nxt     = r_gnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_sel_nxt   = w_pick;
          w_gnt_nxt   = 8'b1 << w_pick;
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (w_rel_last || w_abort || w_force) begin
          w_state_nxt   = ST_IDLE;
          w_ptr_nxt     = r_sel + 3'd1;
          w_gnt_nxt     = 8'd0;
          w_timeout_nxt = w_force;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= 3'd0;
      r_sel     <= 3'd0;
      r_gnt     <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_sel     <= w_sel_nxt;
      r_gnt     <= w_gnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_mux8_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_mux8_arbiter
// Description : Directed self-checking bench for rr_mux8_arbiter; the timeout
//               scenario follows RR_MUX_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux8_arbiter;

`ifdef RR_MUX_TIMEOUT_EN
  localparam int C_MAX_HOLD = 4;
`else
  localparam int C_MAX_HOLD = 16;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  req, last;
  logic [63:0] data;
  logic        y_ready;
  logic [7:0]  gnt;
  logic [2:0]  sel;
  logic [7:0]  y;
  logic        y_valid, y_last, busy, timeout;

  int errors = 0;
  int checks = 0;

  rr_mux8_arbiter #(.WIDTH(8), .MAX_HOLD(C_MAX_HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .last(last), .data(data),
    .gnt(gnt), .sel(sel), .y(y), .y_valid(y_valid), .y_last(y_last),
    .y_ready(y_ready), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req = 8'h00; last = 8'h00; y_ready = 1'b0;
    for (int i = 0; i < 8; i++) data[i*8 +: 8] = 8'hA0 + 8'(i);
    #12;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = 8'hFF; last = 8'hFF; y_ready = 1'b1;
    for (int i = 0; i < 8; i++) data[i*8 +: 8] = 8'hA0 + 8'(i);
    #12;
    checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL rst_gnt: got %h want 00", gnt); end
    checks++; if (sel !== 3'd0) begin errors++; $display("FAIL rst_sel: got %0d want 0", sel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL rst_yvalid: got %b want 0", y_valid); end
    checks++; if (y_last !== 1'b0) begin errors++; $display("FAIL rst_ylast: got %b want 0", y_last); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b want 0", timeout); end
    checks++; if (y !== 8'hA0) begin errors++; $display("FAIL rst_y: got %h want a0", y); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req = 8'h08; last = 8'h00; y_ready = 1'b0;
    tick();
    checks++; if (gnt !== 8'h08) begin errors++; $display("FAIL mid_gnt_pre: got %h want 08", gnt); end
    checks++; if (sel !== 3'd3) begin errors++; $display("FAIL mid_sel_pre: got %0d want 3", sel); end
    checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL mid_yvalid_pre: got %b want 1", y_valid); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL mid_gnt_async: got %h want 00", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_async: got %b want 0", busy); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL mid_yvalid_async: got %b want 0", y_valid); end
    #2;
    reset_n = 1'b1;
    req = 8'h81;
    tick();
    checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL mid_regrant_gnt: got %h want 01", gnt); end
    checks++; if (y !== 8'hA0) begin errors++; $display("FAIL mid_regrant_y: got %h want a0", y); end
    req = 8'h00;
    tick();
  endtask

  task automatic test_round_robin();
    logic [7:0] eg;
    do_reset();
    req = 8'hFF; last = 8'hFF; y_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      eg = 8'h01 << (k % 8);
      tick();
      checks++; if (gnt !== eg) begin errors++; $display("FAIL rr_gnt[%0d]: got %h want %h", k, gnt, eg); end
      checks++; if (sel !== 3'(k % 8)) begin errors++; $display("FAIL rr_sel[%0d]: got %0d want %0d", k, sel, k % 8); end
      checks++; if (y !== 8'hA0 + 8'(k % 8)) begin errors++; $display("FAIL rr_y[%0d]: got %h want %h", k, y, 8'hA0 + 8'(k % 8)); end
      checks++; if (y_last !== 1'b1) begin errors++; $display("FAIL rr_ylast[%0d]: got %b want 1", k, y_last); end
      tick();
      checks++; if (gnt !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL rr_idle[%0d]: got gnt %h busy %b want 00 0", k, gnt, busy); end
      checks++; if (y_valid !== 1'b0 || sel !== 3'(k % 8)) begin errors++; $display("FAIL rr_idle_sel[%0d]: got yv %b sel %0d want 0 %0d", k, y_valid, sel, k % 8); end
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_burst_stall();
    logic [5:0] rdy;
    int beat;
    int nx;
    rdy = 6'b110011;
    beat = 0;
    nx = 0;
    req = 8'h20; last = 8'h00; y_ready = 1'b0;
    tick();
    for (int c = 0; c < 6; c++) begin
      y_ready = rdy[c];
      data[40 +: 8] = 8'h50 + 8'(beat);
      last[5] = (beat == 3);
      #1;
      checks++; if (gnt !== 8'h20) begin errors++; $display("FAIL bs_gnt[%0d]: got %h want 20", c, gnt); end
      checks++; if (y !== 8'h50 + 8'(beat)) begin errors++; $display("FAIL bs_y[%0d]: got %h want %h", c, y, 8'h50 + 8'(beat)); end
      checks++; if (y_last !== (beat == 3)) begin errors++; $display("FAIL bs_ylast[%0d]: got %b want %b", c, y_last, beat == 3); end
      if (y_valid && y_ready) nx++;
      if (rdy[c]) beat++;
      tick();
    end
    checks++; if (nx !== 4) begin errors++; $display("FAIL bs_count: got %0d want 4", nx); end
    checks++; if (gnt !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL bs_release: got gnt %h busy %b want 00 0", gnt, busy); end
    req = 8'h00; last = 8'h00;
    data[40 +: 8] = 8'hA5;
    tick();
  endtask

  task automatic test_abort();
    req = 8'h0C; last = 8'h00; y_ready = 1'b1;
    tick();
    checks++; if (gnt !== 8'h04) begin errors++; $display("FAIL ab_gnt: got %h want 04", gnt); end
    checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL ab_beat1: got %b want 1", y_valid); end
    tick();
    req = 8'h08;
    #1;
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL ab_yvalid_drop: got %b want 0", y_valid); end
    tick();
    checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL ab_release: got %h want 00", gnt); end
    tick();
    checks++; if (gnt !== 8'h08 || sel !== 3'd3) begin errors++; $display("FAIL ab_next: got gnt %h sel %0d want 08 3", gnt, sel); end
    req = 8'h00;
    tick();
  endtask

  task automatic test_timeout();
    req = 8'hC0; last = 8'h00; y_ready = 1'b0;
    tick();
`ifdef RR_MUX_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      checks++; if (gnt !== 8'h40 || timeout !== 1'b0) begin errors++; $display("FAIL to_hold[%0d]: got gnt %h to %b want 40 0", c, gnt, timeout); end
      tick();
    end
    checks++; if (gnt !== 8'h00 || timeout !== 1'b1) begin errors++; $display("FAIL to_fire: got gnt %h to %b want 00 1", gnt, timeout); end
    tick();
    checks++; if (gnt !== 8'h80 || timeout !== 1'b0) begin errors++; $display("FAIL to_next: got gnt %h to %b want 80 0", gnt, timeout); end
`else
    for (int c = 0; c < 100; c++) begin
      checks++; if (gnt !== 8'h40 || timeout !== 1'b0) begin errors++; $display("FAIL to_off[%0d]: got gnt %h to %b want 40 0", c, gnt, timeout); end
      tick();
    end
`endif
    req = 8'h00;
    tick();
  endtask

  initial begin
    test_reset();
    test_reset_mid_burst();
    test_round_robin();
    test_burst_stall();
    test_abort();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
